// File: rtl/ram_arbiter_if.sv
// Requester-side command/response bundle for one port of the shared RAM arbiter.
// The requester is the master; the arbiter is the slave.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     valid;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     ready;
    logic                     rvalid;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters.
// One command per cycle; reads return a fixed two cycles after the command transfers.
module ram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    ram_arbiter_if.slave             port_a,
    ram_arbiter_if.slave             port_b,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    owner_t                   last_grant;
    owner_t                   s1_owner;
    owner_t                   s2_owner;
    logic                     s1_pending;
    logic                     s2_pending;

    logic                     grant_a;
    logic                     grant_b;
    logic                     xfer;
    owner_t                   sel_owner;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;

    // Readies are gated by resetn so nothing can transfer while reset is held.
    always_comb begin
        grant_a   = resetn && port_a.valid && (!port_b.valid || last_grant == OWNER_B);
        grant_b   = resetn && port_b.valid && (!port_a.valid || last_grant == OWNER_A);
        xfer      = grant_a || grant_b;
        sel_owner = grant_b ? OWNER_B : OWNER_A;
        sel_we    = grant_b ? port_b.we    : port_a.we;
        sel_addr  = grant_b ? port_b.addr  : port_a.addr;
        sel_wdata = grant_b ? port_b.wdata : port_a.wdata;
    end

    assign port_a.ready = grant_a;
    assign port_b.ready = grant_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= OWNER_B;
            ram_wEn    <= 1'b0;
            ram_addr   <= '0;
            ram_dataIn <= '0;
            s1_pending <= 1'b0;
            s1_owner   <= OWNER_A;
            s2_pending <= 1'b0;
            s2_owner   <= OWNER_A;
        end else begin
            ram_wEn <= xfer && sel_we;
            if (xfer) begin
                last_grant <= sel_owner;
                ram_addr   <= sel_addr;
                ram_dataIn <= sel_wdata;
            end
            // Stage 2 lines up with the RAM's registered read data.
            s1_pending <= xfer && !sel_we;
            s1_owner   <= sel_owner;
            s2_pending <= s1_pending;
            s2_owner   <= s1_owner;
        end
    end

    assign port_a.rvalid = s2_pending && (s2_owner == OWNER_A);
    assign port_b.rvalid = s2_pending && (s2_owner == OWNER_B);
    assign port_a.rdata  = ram_dataOut;
    assign port_b.rdata  = ram_dataOut;

endmodule
